audio_filter_ctrl: RTL and testbench
====================================

# audio_filter_ctrl

Sample-sequencing controller between the audio codec's read/write FIFO handshake and the left/right `FIR_Filter` pair. Per stereo frame it:
- pops one sample pair from the codec,
- presents it to both filters and issues a single `en` pulse,
- captures the filtered (or bypassed) result,
- pushes it back to the codec.

It also counts processed frames and flags frames dropped because the codec write side stalled.

## Interface
Parameters:
- TIMEOUT, default 1024: max consecutive cycles spent waiting for write_ready before the frame is dropped; must be ≥ 1.
- CNT_W, default 16: width of sample_count.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- read_ready  in  1  codec input FIFO holds a sample pair.
- readdata_left  in  24  codec left sample, two's complement.
- readdata_right  in  24  codec right sample, two's complement.
- read  out  1  one-cycle pop strobe to codec input FIFO.
- write_ready  in  1  codec output FIFO can accept a sample pair.
- writedata_left  out  24  left sample to codec.
- writedata_right  out  24  right sample to codec.
- write  out  1  one-cycle push strobe to codec output FIFO.
- filt_in_left  out  24  left filter dataIn.
- filt_in_right  out  24  right filter dataIn.
- filt_en  out  1  shared filter en.
- filt_out_left  in  24  left filter dataOut; combinational, valid during filt_en.
- filt_out_right  in  24  right filter dataOut.
- bypass  in  1  1 = pass raw samples to the codec.
- clr_overrun  in  1  clears the overrun flag.
- sample_count  out  CNT_W  frames written since reset; wraps.
- overrun  out  1  sticky; set when a frame is dropped.

## Operation
- FSM states: IDLE, READ, FILT, WAIT_WR, WRITE. Outputs read, filt_en and write are Moore-decoded: read=1 only in READ, filt_en=1 only in FILT, write=1 only in WRITE.
- IDLE: go to READ when read_ready=1; otherwise stay.
- READ (1 cycle):
  - latch readdata_left/right into filt_in_left/right;
  - latch bypass into bypass_q;
  - go to FILT.
- FILT (1 cycle):
  - filters accumulate at this edge;
  - writedata_left/right ← bypass_q ? filt_in_left/right : filt_out_left/right;
  - clear wait counter;
  - go to WAIT_WR.
- Filters are enabled in bypass mode too. Their history stays current, so toggling bypass is glitch-free.
- WAIT_WR:
  - write_ready=1 → WRITE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT-1 with write_ready still 0 → IDLE, overrun←1, sample_count unchanged, frame discarded.
  - If write_ready=1 on the timeout cycle, the write wins (→ WRITE, no overrun).
- WRITE (1 cycle): sample_count ← sample_count+1, wrapping from 2^CNT_W−1 to 0; go to IDLE.
- overrun:
  - set by the timeout event; cleared when clr_overrun=1;
  - set and clear in the same cycle → set wins.
- bypass is sampled only in READ. Changing it mid-frame has no effect until the next frame.
- writedata and filt_in hold their values between frames. They change only at the READ and FILT edges.

## Timing
- Reset (any state, any cycle): state=IDLE. read=write=filt_en=0, filt_in_*=0, writedata_*=0, sample_count=0, overrun=0, wait counter=0, bypass_q=0.
  - An in-flight frame is abandoned with no read, write or filt_en pulse emitted.
  - The filters share the same reset.
- Frame timeline, with read_ready first seen high in IDLE at cycle t:
  - read=1 in t+1;
  - filt_en=1 in t+2;
  - writedata valid from t+3;
  - with write_ready=1 at t+3, write=1 in t+4 and sample_count updates at the end of t+4;
  - IDLE at t+5.
- Minimum frame period: 5 cycles. Read-to-write latency: 3 cycles.
- The codec must present readdata valid while read_ready=1. The controller latches it in the READ cycle, i.e. the same cycle as the pop strobe.
- Exactly one filt_en pulse per popped frame, including dropped frames: the filter has already advanced.
- read_ready arriving while busy is ignored until the return to IDLE. The controller never pops more than one frame ahead.
- Timeout path: the transition to IDLE happens exactly TIMEOUT cycles after entering WAIT_WR.

## Test plan
- Reset mid-frame: assert reset in the FILT cycle → next cycle all outputs 0 and state IDLE; no write pulse ever appears for that frame.
- Single frame, bypass=0, write_ready=1, readdata_left=400, readdata_right=−8, filters SIZE=4, fresh from reset:
  - read at t+1, filt_en at t+2, write at t+4;
  - writedata_left=100, writedata_right=−2;
  - sample_count=1.
- Bypass: same stimulus with bypass=1 → writedata_left=400, writedata_right=−8. Filter accumulators still advance; checked on the next frame with bypass=0.
- Back-to-back frames: read_ready held high for 10 frames → read pulses exactly 5 cycles apart, 10 writes, sample_count=10.
- Write stall and recovery, TIMEOUT=8:
  - write_ready low for 7 cycles, then high → write issued, overrun=0;
  - write_ready low for 8 cycles → no write, overrun=1, sample_count unchanged;
  - clr_overrun for 1 cycle → overrun=0.
- Counter wrap, CNT_W=3: 9 frames → sample_count=1.

Source files
------------

// File: rtl/audio_filter_ctrl.sv
// audio_filter_ctrl: pops one stereo sample pair from the codec, drives the
// left/right FIR filters with one shared enable pulse, then pushes the
// filtered (or raw, in bypass) pair back to the codec.
// Keeps a wrapping frame counter and a sticky overrun flag. The overrun flag
// is set when a frame is dropped because the codec write side stalled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for read_ready
// READ    | pop strobe; latch samples and bypass mode
// FILT    | filter enable; capture filtered/raw result into writedata
// WAIT_WR | waiting for write_ready, bounded by TIMEOUT cycles
// WRITE   | push strobe; bump frame counter

module audio_filter_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read_ready,
    input  logic [23:0]        readdata_left,
    input  logic [23:0]        readdata_right,
    output logic               read,
    input  logic               write_ready,
    output logic [23:0]        writedata_left,
    output logic [23:0]        writedata_right,
    output logic               write,
    output logic [23:0]        filt_in_left,
    output logic [23:0]        filt_in_right,
    output logic               filt_en,
    input  logic [23:0]        filt_out_left,
    input  logic [23:0]        filt_out_right,
    input  logic               bypass,
    input  logic               clr_overrun,
    output logic [CNT_W-1:0]   sample_count,
    output logic               overrun
);

    // The wait counter only ever needs to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        FILT    = 3'd2,
        WAIT_WR = 3'd3,
        WRITE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       filt_in_l_q, filt_in_l_d;
    logic [23:0]       filt_in_r_q, filt_in_r_d;
    logic [23:0]       wr_l_q, wr_l_d;
    logic [23:0]       wr_r_q, wr_r_d;
    logic              bypass_q, bypass_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              timeout;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            filt_in_l_q <= '0;
            filt_in_r_q <= '0;
            wr_l_q      <= '0;
            wr_r_q      <= '0;
            bypass_q    <= 1'b0;
            wait_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_in_l_q <= filt_in_l_d;
            filt_in_r_q <= filt_in_r_d;
            wr_l_q      <= wr_l_d;
            wr_r_q      <= wr_r_d;
            bypass_q    <= bypass_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, datapath updates and Moore strobes.
    always_comb begin
        state_d     = state_q;
        filt_in_l_d = filt_in_l_q;
        filt_in_r_d = filt_in_r_q;
        wr_l_d      = wr_l_q;
        wr_r_d      = wr_r_q;
        bypass_d    = bypass_q;
        wait_d      = wait_q;
        count_d     = count_q;
        timeout     = 1'b0;
        read        = 1'b0;
        filt_en     = 1'b0;
        write       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (read_ready) state_d = READ;
            end
            READ: begin
                read        = 1'b1;
                filt_in_l_d = readdata_left;
                filt_in_r_d = readdata_right;
                bypass_d    = bypass;
                state_d     = FILT;
            end
            FILT: begin
                filt_en = 1'b1;
                wr_l_d  = bypass_q ? filt_in_l_q : filt_out_left;
                wr_r_d  = bypass_q ? filt_in_r_q : filt_out_right;
                wait_d  = '0;
                state_d = WAIT_WR;
            end
            WAIT_WR: begin
                // A write that becomes possible on the final wait cycle still wins.
                if (write_ready) begin
                    state_d = WRITE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WRITE: begin
                write   = 1'b1;
                count_d = count_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over clear so a drop is never lost.
        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (timeout)     overrun_d = 1'b1;
    end

    assign filt_in_left    = filt_in_l_q;
    assign filt_in_right   = filt_in_r_q;
    assign writedata_left  = wr_l_q;
    assign writedata_right = wr_r_q;
    assign sample_count    = count_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_audio_filter_ctrl.sv
module tb_audio_filter_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_ready;
    logic [23:0] readdata_left, readdata_right;
    logic        write_ready;
    logic        bypass;
    logic        clr_overrun;
    logic [23:0] filt_out_left, filt_out_right;

    logic        read, write, filt_en;
    logic [23:0] writedata_left, writedata_right, filt_in_left, filt_in_right;
    logic [15:0] sample_count;
    logic        overrun;

    logic        b_read, b_write, b_filt_en, b_overrun;
    logic [23:0] b_wd_l, b_wd_r, b_fi_l, b_fi_r;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_filter_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .read_ready(read_ready), .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(read), .write_ready(write_ready),
        .writedata_left(writedata_left), .writedata_right(writedata_right), .write(write),
        .filt_in_left(filt_in_left), .filt_in_right(filt_in_right), .filt_en(filt_en),
        .filt_out_left(filt_out_left), .filt_out_right(filt_out_right),
        .bypass(bypass), .clr_overrun(clr_overrun),
        .sample_count(sample_count), .overrun(overrun)
    );

    // Narrow-counter instance; sees identical stimulus so it runs in lockstep.
    audio_filter_ctrl #(.TIMEOUT(8), .CNT_W(3)) dut_w (
        .clk(clk), .reset(reset),
        .read_ready(read_ready), .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(b_read), .write_ready(write_ready),
        .writedata_left(b_wd_l), .writedata_right(b_wd_r), .write(b_write),
        .filt_in_left(b_fi_l), .filt_in_right(b_fi_r), .filt_en(b_filt_en),
        .filt_out_left(filt_out_left), .filt_out_right(filt_out_right),
        .bypass(bypass), .clr_overrun(clr_overrun),
        .sample_count(b_count), .overrun(b_overrun)
    );

    // Reference 4-tap moving-average FIR: out = (x + h0 + h1 + h2) / 4.
    logic [23:0] hl [3];
    logic [23:0] hr [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                hl[i] <= '0;
                hr[i] <= '0;
            end
        end else if (filt_en) begin
            hl[0] <= filt_in_left;  hl[1] <= hl[0]; hl[2] <= hl[1];
            hr[0] <= filt_in_right; hr[1] <= hr[0]; hr[2] <= hr[1];
        end
    end

    function automatic logic [25:0] sx(input logic [23:0] v);
        return {{2{v[23]}}, v};
    endfunction

    always_comb begin
        logic [25:0] sl, sr;
        sl = sx(filt_in_left) + sx(hl[0]) + sx(hl[1]) + sx(hl[2]);
        sr = sx(filt_in_right) + sx(hr[0]) + sx(hr[1]) + sx(hr[2]);
        filt_out_left  = sl[25:2];
        filt_out_right = sr[25:2];
    end

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        read_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge while the controller is idle; that cycle is t.
    task automatic start_frame(input logic [23:0] l, input logic [23:0] r, input logic b);
        read_ready     = 1'b1;
        readdata_left  = l;
        readdata_right = r;
        bypass         = b;
    endtask

    // Holds read_ready high until n pops are seen, then waits for n pushes.
    task automatic run_frames(input int n, output int nreads, output int nwrites, output int bad_gaps);
        int cyc, last_rd;
        nreads = 0; nwrites = 0; bad_gaps = 0; cyc = 0; last_rd = -1;
        write_ready = 1'b1;
        read_ready  = 1'b1;
        while (cyc < 200 && nwrites < n) begin
            @(negedge clk);
            cyc++;
            if (write) nwrites++;
            if (read) begin
                if (last_rd >= 0 && cyc - last_rd != 5) bad_gaps++;
                last_rd = cyc;
                nreads++;
                if (nreads == n) read_ready = 1'b0;
            end
        end
        read_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        if (read !== 1'b0)  begin errors++; $display("FAIL reset_read got %0b want 0", read); end
        if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %0b want 0", write); end
        if (filt_en !== 1'b0) begin errors++; $display("FAIL reset_filt_en got %0b want 0", filt_en); end
        if (writedata_left !== 24'd0) begin errors++; $display("FAIL reset_wd_left got %h want 0", writedata_left); end
        if (filt_in_right !== 24'd0) begin errors++; $display("FAIL reset_fi_right got %h want 0", filt_in_right); end
        if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
        if (b_count !== 3'd0) begin errors++; $display("FAIL reset_count_w got %0d want 0", b_count); end
        checks += 8;
    endtask

    task automatic test_single_frame();
        write_ready = 1'b1;
        @(negedge clk);
        start_frame(24'd400, 24'hFFFFF8, 1'b0);
        @(negedge clk);  // t+1
        checks += 2;
        if (read !== 1'b1)    begin errors++; $display("FAIL single_read got %0b want 1", read); end
        if (filt_en !== 1'b0) begin errors++; $display("FAIL single_fe_early got %0b want 0", filt_en); end
        read_ready = 1'b0;
        @(negedge clk);  // t+2
        checks += 3;
        if (filt_en !== 1'b1) begin errors++; $display("FAIL single_filt_en got %0b want 1", filt_en); end
        if (filt_in_left !== 24'd400) begin errors++; $display("FAIL single_fi_left got %0d want 400", filt_in_left); end
        if (filt_in_right !== 24'hFFFFF8) begin errors++; $display("FAIL single_fi_right got %h want fffff8", filt_in_right); end
        @(negedge clk);  // t+3
        checks += 3;
        if (writedata_left !== 24'd100) begin errors++; $display("FAIL single_wd_left got %0d want 100", writedata_left); end
        if (writedata_right !== 24'hFFFFFE) begin errors++; $display("FAIL single_wd_right got %h want fffffe", writedata_right); end
        if (write !== 1'b0) begin errors++; $display("FAIL single_write_early got %0b want 0", write); end
        @(negedge clk);  // t+4
        checks += 2;
        if (write !== 1'b1) begin errors++; $display("FAIL single_write got %0b want 1", write); end
        if (sample_count !== 16'd0) begin errors++; $display("FAIL single_count_early got %0d want 0", sample_count); end
        @(negedge clk);  // t+5
        checks += 2;
        if (sample_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", sample_count); end
        if (write !== 1'b0) begin errors++; $display("FAIL single_write_late got %0b want 0", write); end
    endtask

    task automatic test_bypass();
        apply_reset();
        write_ready = 1'b1;
        start_frame(24'd400, 24'hFFFFF8, 1'b1);
        @(negedge clk);  // t+1
        read_ready = 1'b0;
        @(negedge clk);  // t+2: mode already latched, flipping it must not matter
        bypass = 1'b0;
        @(negedge clk);  // t+3
        checks += 2;
        if (writedata_left !== 24'd400) begin errors++; $display("FAIL bypass_wd_left got %0d want 400", writedata_left); end
        if (writedata_right !== 24'hFFFFF8) begin errors++; $display("FAIL bypass_wd_right got %h want fffff8", writedata_right); end
        repeat (2) @(negedge clk);
        // Filter history advanced during the bypassed frame: (0+400)/4, (0-8)/4.
        start_frame(24'd0, 24'd0, 1'b0);
        @(negedge clk);
        read_ready = 1'b0;
        repeat (2) @(negedge clk);  // t+3
        checks += 2;
        if (writedata_left !== 24'd100) begin errors++; $display("FAIL bypass_hist_left got %0d want 100", writedata_left); end
        if (writedata_right !== 24'hFFFFFE) begin errors++; $display("FAIL bypass_hist_right got %h want fffffe", writedata_right); end
        repeat (2) @(negedge clk);
        checks++;
        if (sample_count !== 16'd2) begin errors++; $display("FAIL bypass_count got %0d want 2", sample_count); end
    endtask

    task automatic test_back_to_back();
        int nr, nw, bg;
        readdata_left = 24'd8; readdata_right = 24'd4; bypass = 1'b0;
        run_frames(10, nr, nw, bg);
        checks += 4;
        if (nr !== 10) begin errors++; $display("FAIL b2b_reads got %0d want 10", nr); end
        if (nw !== 10) begin errors++; $display("FAIL b2b_writes got %0d want 10", nw); end
        if (bg !== 0)  begin errors++; $display("FAIL b2b_gap got %0d bad gaps want 0", bg); end
        if (sample_count !== 16'd12) begin errors++; $display("FAIL b2b_count got %0d want 12", sample_count); end
    endtask

    task automatic test_stall();
        int wseen;
        // Seven stalled cycles, write on the eighth (last allowed) cycle.
        write_ready = 1'b0;
        @(negedge clk);
        start_frame(24'd4, 24'd4, 1'b0);
        @(negedge clk);
        read_ready = 1'b0;
        @(negedge clk);  // t+2
        wseen = 0;
        repeat (8) begin
            @(negedge clk);
            if (write) wseen++;
        end
        write_ready = 1'b1;  // t+10
        @(negedge clk);      // t+11
        checks += 3;
        if (wseen !== 0)    begin errors++; $display("FAIL stall_early_write got %0d want 0", wseen); end
        if (write !== 1'b1) begin errors++; $display("FAIL stall_write got %0b want 1", write); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL stall_overrun got %0b want 0", overrun); end
        @(negedge clk);
        checks++;
        if (sample_count !== 16'd13) begin errors++; $display("FAIL stall_count got %0d want 13", sample_count); end

        // Eight stalled cycles: frame dropped.
        write_ready = 1'b0;
        start_frame(24'd4, 24'd4, 1'b0);
        @(negedge clk);
        read_ready = 1'b0;
        @(negedge clk);  // t+2
        wseen = 0;
        repeat (8) begin
            @(negedge clk);
            if (write) wseen++;
        end
        checks++;        // t+10
        if (overrun !== 1'b0) begin errors++; $display("FAIL drop_overrun_early got %0b want 0", overrun); end
        @(negedge clk);  // t+11
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun got %0b want 1", overrun); end
        repeat (4) begin
            @(negedge clk);
            if (write) wseen++;
        end
        checks += 2;
        if (wseen !== 0) begin errors++; $display("FAIL drop_write got %0d want 0", wseen); end
        if (sample_count !== 16'd13) begin errors++; $display("FAIL drop_count got %0d want 13", sample_count); end
        write_ready = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int wseen;
        write_ready = 1'b1;
        @(negedge clk);
        start_frame(24'd4, 24'd4, 1'b0);
        @(negedge clk);
        read_ready = 1'b0;
        @(negedge clk);  // FILT
        checks++;
        if (filt_en !== 1'b1) begin errors++; $display("FAIL midrst_filt_en got %0b want 1", filt_en); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 6;
        if (filt_en !== 1'b0) begin errors++; $display("FAIL midrst_fe got %0b want 0", filt_en); end
        if (read !== 1'b0) begin errors++; $display("FAIL midrst_read got %0b want 0", read); end
        if (filt_in_left !== 24'd0) begin errors++; $display("FAIL midrst_fi_left got %0d want 0", filt_in_left); end
        if (writedata_left !== 24'd0) begin errors++; $display("FAIL midrst_wd_left got %0d want 0", writedata_left); end
        if (writedata_right !== 24'd0) begin errors++; $display("FAIL midrst_wd_right got %0d want 0", writedata_right); end
        if (sample_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", sample_count); end
        wseen = 0;
        repeat (8) begin
            if (write) wseen++;
            @(negedge clk);
        end
        checks++;
        if (wseen !== 0) begin errors++; $display("FAIL midrst_write got %0d want 0", wseen); end
    endtask

    task automatic test_wrap();
        int nr, nw, bg;
        apply_reset();
        run_frames(9, nr, nw, bg);
        checks += 3;
        if (nw !== 9) begin errors++; $display("FAIL wrap_writes got %0d want 9", nw); end
        if (b_count !== 3'd1) begin errors++; $display("FAIL wrap_count_w got %0d want 1", b_count); end
        if (sample_count !== 16'd9) begin errors++; $display("FAIL wrap_count got %0d want 9", sample_count); end
    endtask

    initial begin
        reset = 1'b1; read_ready = 1'b0; readdata_left = '0; readdata_right = '0;
        write_ready = 1'b0; bypass = 1'b0; clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single_frame();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
